// File: rtl/m68k_bus_pkg.sv
// Shared types and address-map constants for the SCC68070 to mcd212 bus bridge.
package m68k_bus_pkg;

    localparam int unsigned ADDR_W     = 23;
    localparam int unsigned MCD_ADDR_W = 22;
    localparam int unsigned DATA_W     = 16;

    // Byte-address map shared with mcd212's own decode
    localparam logic [22:0] DRAM_BASE  = 23'h000000;
    localparam logic [22:0] DRAM_TOP   = 23'h3fffff;
    localparam logic [22:0] ROM_BASE   = 23'h400000;
    localparam logic [22:0] ROM_TOP    = 23'h4fffbf;
    localparam logic [22:0] IO_BASE    = 23'h4fffc0;
    localparam logic [22:0] MCD212_TOP = 23'h4fffff;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ACCESS,
        ACK,
        ERROR
    } bridge_state_t;

    // cpu_addr carries A23..A1; A23 set or byte address above top is not mcd212
    function automatic logic is_mcd212(input logic [22:0] word_addr, input logic [22:0] top);
        return !word_addr[22] && ({word_addr[21:0], 1'b0} <= top);
    endfunction

endpackage

// File: rtl/m68k_bus_bridge_bus_sync.sv
// Multi-bit flip-flop synchroniser for active-low async strobes; resets deasserted (1).
module bus_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES*WIDTH-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[(SYNC_STAGES-1)*WIDTH-1:0], d_i};
        end
    end

    assign q_o = chain_q[SYNC_STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/m68k_bus_bridge.sv
// SCC68070 async bus to mcd212 request bridge with DTACK/BERR generation.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module m68k_bus_bridge
    import m68k_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [22:0] DECODE_TOP     = MCD212_TOP
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_as_n,
    input  logic                  cpu_uds_n,
    input  logic                  cpu_lds_n,
    input  logic                  cpu_rw,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_dout,
    output logic [DATA_W-1:0]     cpu_din,
    output logic                  cpu_dtack_n,
    output logic                  cpu_berr_n,
    output logic [MCD_ADDR_W-1:0] address,
    output logic [DATA_W-1:0]     din,
    input  logic [DATA_W-1:0]     dout,
    output logic                  uds,
    output logic                  lds,
    output logic                  write_strobe,
    input  logic                  bus_ack,
    output logic                  cs
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0] sync_s;
    logic       as_s, uds_s, lds_s;

    bus_sync #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   ({cpu_as_n, cpu_uds_n, cpu_lds_n}),
        .q_o   (sync_s)
    );

    assign {as_s, uds_s, lds_s} = sync_s;

    bridge_state_t         state_q, state_d;
    logic                  cs_q, cs_d, uds_q, uds_d, lds_q, lds_d, we_q, we_d;
    logic                  dtack_n_q, dtack_n_d, berr_n_q, berr_n_d;
    logic [MCD_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     din_q, din_d, cpu_din_q, cpu_din_d;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            we_q      <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            cpu_din_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            we_q      <= we_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            cpu_din_q <= cpu_din_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next state and registered request/response updates
    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        we_d      = we_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;
        addr_d    = addr_q;
        din_d     = din_q;
        cpu_din_d = cpu_din_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!as_s && (!uds_s || !lds_s)) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                addr_d = cpu_addr[MCD_ADDR_W-1:0];
                din_d  = cpu_dout;
`ifdef BUS_TIMEOUT_EN
                cnt_d  = '0;
`endif
                // Strobes only reach mcd212 for accesses it owns
                if (is_mcd212(cpu_addr, DECODE_TOP)) begin
                    cs_d    = 1'b1;
                    uds_d   = !uds_s;
                    lds_d   = !lds_s;
                    we_d    = !cpu_rw;
                    state_d = ACCESS;
                end else begin
                    berr_n_d = 1'b0;
                    state_d  = ERROR;
                end
            end
            ACCESS: begin
                if (as_s) begin
                    cs_d    = 1'b0;
                    uds_d   = 1'b0;
                    lds_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end else if (bus_ack) begin
                    if (!we_q) begin
                        cpu_din_d = dout;
                    end
                    dtack_n_d = 1'b0;
                    cs_d      = 1'b0;
                    uds_d     = 1'b0;
                    lds_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = ACK;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    berr_n_d = 1'b0;
                    cs_d     = 1'b0;
                    uds_d    = 1'b0;
                    lds_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ACK: begin
                if (as_s) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ERROR: begin
                if (as_s) begin
                    berr_n_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cs           = cs_q;
    assign uds          = uds_q;
    assign lds          = lds_q;
    assign write_strobe = we_q;
    assign address      = addr_q;
    assign din          = din_q;
    assign cpu_din      = cpu_din_q;
    assign cpu_dtack_n  = dtack_n_q;
    assign cpu_berr_n   = berr_n_q;

endmodule
